hazard5_regfile_mwnr: RTL

Parametrised multi-port successor to the Hazard5 1-write/2-read register file: `N_WPORTS` write ports and `N_RPORTS` read ports, registered read data with write-to-read bypass, and hold-while-stalled semantics. It sits in the decode stage. Read ports feed operand latches; write ports come from writeback and, in dual-issue or load-return configurations, a second retire path. Write collisions resolve deterministically, and register 0 is optionally hardwired to zero.

---
 rtl/hazard5_regfile_mwnr_pkg.sv | 20 ++
 rtl/hazard5_regfile_rport.sv | 83 ++++++++
 rtl/hazard5_regfile_mwnr.sv | 94 +++++++++
 3 files changed

// File: rtl/hazard5_regfile_mwnr_pkg.sv
// Shared definitions for the multi-port Hazard5 register file: port-packing
// helpers and the legal port-count ranges.
package hazard5_regfile_mwnr_pkg;

    localparam int RPORTS_MIN = 1;
    localparam int RPORTS_MAX = 4;
    localparam int WPORTS_MIN = 1;
    localparam int WPORTS_MAX = 2;
    localparam int NREGS_MIN  = 2;

    // Low bit of port `port` in a flat vector of `width`-bit fields
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

    function automatic bit count_legal(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

endpackage

// File: rtl/hazard5_regfile_rport.sv
// One read port: negedge storage sample, priority write bypass, stall hold
// tracking via the previous read address, and the zero-register mask.
module hazard5_regfile_rport
    import hazard5_regfile_mwnr_pkg::*;
#(
    parameter int W_DATA   = 32,
    parameter int W_ADDR   = 5,
    parameter int N_WPORTS = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_ren,
    input  logic [W_ADDR-1:0]            i_raddr,
    input  logic [W_DATA-1:0]            i_mem_rdata,
    input  logic [N_WPORTS*W_ADDR-1:0]   i_waddr,
    input  logic [N_WPORTS*W_DATA-1:0]   i_wdata,
    input  logic [N_WPORTS-1:0]          i_wen,
    output logic [W_DATA-1:0]            o_rdata
);

    logic [W_DATA-1:0] r_sample;
    logic [W_DATA-1:0] r_rdata;
    logic [W_ADDR-1:0] r_raddr_prev;

    logic              w_hit;
    logic [W_DATA-1:0] w_byp;
    logic              w_hit_prev;
    logic [W_DATA-1:0] w_byp_prev;
    logic              w_addr_zero;
    logic              w_prev_zero;

    // Ascending scan so the highest-indexed matching write port wins
    always_comb begin
        w_hit      = 1'b0;
        w_byp      = '0;
        w_hit_prev = 1'b0;
        w_byp_prev = '0;
        for (int w = 0; w < N_WPORTS; w++) begin
            if (i_wen[w] && (i_waddr[slice_lo(w, W_ADDR) +: W_ADDR] == i_raddr)) begin
                w_hit = 1'b1;
                w_byp = i_wdata[slice_lo(w, W_DATA) +: W_DATA];
            end
            if (i_wen[w] && (i_waddr[slice_lo(w, W_ADDR) +: W_ADDR] == r_raddr_prev)) begin
                w_hit_prev = 1'b1;
                w_byp_prev = i_wdata[slice_lo(w, W_DATA) +: W_DATA];
            end
        end
        w_addr_zero = (ZERO_REG != 0) && (i_raddr == '0);
        w_prev_zero = (ZERO_REG != 0) && (r_raddr_prev == '0);
    end

    // Sampled every negedge regardless of ren, which arrives too late to gate it
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample <= '0;
        end else begin
            r_sample <= i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata      <= '0;
            r_raddr_prev <= '0;
        end else if (i_ren) begin
            r_raddr_prev <= i_raddr;
            if (w_addr_zero) begin
                r_rdata <= '0;
            end else if (w_hit) begin
                r_rdata <= w_byp;
            end else begin
                r_rdata <= r_sample;
            end
        end else if (w_hit_prev && !w_prev_zero) begin
            // Stalled operand tracks writes to the register it holds
            r_rdata <= w_byp_prev;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hazard5_regfile_mwnr.sv
// Hazard5 register file with N write ports and M registered read ports,
// write-to-read bypass and hold-while-stalled read data.
module hazard5_regfile_mwnr
    import hazard5_regfile_mwnr_pkg::*;
#(
    parameter int RESET_REGS = 0,
    parameter int N_REGS     = 32,
    parameter int W_DATA     = 32,
    parameter int W_ADDR     = $clog2(N_REGS),
    parameter int N_RPORTS   = 2,
    parameter int N_WPORTS   = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ren,
    input  logic [N_RPORTS*W_ADDR-1:0]  raddr,
    output logic [N_RPORTS*W_DATA-1:0]  rdata,
    input  logic [N_WPORTS*W_ADDR-1:0]  waddr,
    input  logic [N_WPORTS*W_DATA-1:0]  wdata,
    input  logic [N_WPORTS-1:0]         wen
);

    if (!count_legal(N_RPORTS, RPORTS_MIN, RPORTS_MAX)) begin : g_bad_rports
        $error("hazard5_regfile_mwnr: N_RPORTS out of range 1..4");
    end
    if (!count_legal(N_WPORTS, WPORTS_MIN, WPORTS_MAX)) begin : g_bad_wports
        $error("hazard5_regfile_mwnr: N_WPORTS out of range 1..2");
    end
    if (N_REGS < NREGS_MIN) begin : g_bad_nregs
        $error("hazard5_regfile_mwnr: N_REGS must be at least 2");
    end

    logic [W_DATA-1:0]   r_mem [N_REGS];
    logic [N_WPORTS-1:0] w_wr_ok;

    always_comb begin
        w_wr_ok = '0;
        for (int w = 0; w < N_WPORTS; w++) begin
            w_wr_ok[w] = wen[w] &&
                !((ZERO_REG != 0) && (waddr[slice_lo(w, W_ADDR) +: W_ADDR] == '0));
        end
    end

    // Later ports are assigned last, so the higher index wins a collision
    if (RESET_REGS != 0) begin : g_mem_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N_REGS; i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                for (int w = 0; w < N_WPORTS; w++) begin
                    if (w_wr_ok[w]) begin
                        r_mem[waddr[slice_lo(w, W_ADDR) +: W_ADDR]] <=
                            wdata[slice_lo(w, W_DATA) +: W_DATA];
                    end
                end
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge clk) begin
            for (int w = 0; w < N_WPORTS; w++) begin
                if (w_wr_ok[w]) begin
                    r_mem[waddr[slice_lo(w, W_ADDR) +: W_ADDR]] <=
                        wdata[slice_lo(w, W_DATA) +: W_DATA];
                end
            end
        end
    end

    for (genvar p = 0; p < N_RPORTS; p++) begin : g_rport
        logic [W_ADDR-1:0] w_raddr;
        assign w_raddr = raddr[p*W_ADDR +: W_ADDR];

        hazard5_regfile_rport #(
            .W_DATA   (W_DATA),
            .W_ADDR   (W_ADDR),
            .N_WPORTS (N_WPORTS),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_ren       (ren),
            .i_raddr     (w_raddr),
            .i_mem_rdata (r_mem[w_raddr]),
            .i_waddr     (waddr),
            .i_wdata     (wdata),
            .i_wen       (wen),
            .o_rdata     (rdata[p*W_DATA +: W_DATA])
        );
    end

endmodule
